lfsr_gen: RTL and testbench
===========================

# lfsr_gen

Parametrised Fibonacci linear-feedback shift register for the ALU/test-pattern datapath. It supports any width from 2 to 32 and a programmable tap mask, and loads its seed synchronously with zero-seed protection. It also emits the serial output bit and measures the sequence period on the fly, raising a wrap pulse and latching the period length when the state returns to the loaded seed. It is the successor of the fixed 4-bit shift-only generator and is used as a pseudo-random operand source and self-checking pattern generator.

## Interface
- BIT_WIDTH, 8, register width, legal range 2..32; elaboration `$error` outside this range.
- TAP_MASK, 8'h1D, BIT_WIDTH-bit feedback mask.
  - Bit i set means state bit i feeds the XOR.
  - TAP_MASK[0] must be 1; elaboration `$error` otherwise.
  - The default implements x^8+x^4+x^3+x^2+1 (maximal, period 255).
- clk  in  1  rising-edge clock; one clock domain.
- rstn  in  1  asynchronous, active-low reset.
- load_in  in  1  load seed_in this cycle; has priority over shift_in.
- seed_in  in  BIT_WIDTH  seed value, sampled when load_in=1.
- shift_in  in  1  advance the LFSR one step.
- valid_out  out  1  1-cycle pulse: res_out was updated by a shift.
- res_out  out  BIT_WIDTH  current LFSR state.
- bit_out  out  1  bit shifted out (old state[0]) by the last shift.
- wrap_out  out  1  1-cycle pulse: the last shift returned the state to the reference seed.
- period_out  out  BIT_WIDTH  measured period, latched at wrap.
- period_valid_out  out  1  sticky flag: period_out holds a measured value.
- seed_err_out  out  1  1-cycle pulse: a zero seed was loaded and replaced by 1.

## Operation
- Internal state:
  - `state` (drives res_out).
  - `ref_seed`: the seed actually loaded.
  - `step_cnt`, BIT_WIDTH bits.
- Next-state function:
  - fb = XOR over i of (state[i] & TAP_MASK[i]).
  - next = {fb, state[BIT_WIDTH-1:1]}, i.e. shift right with feedback into the MSB.
- Reset (rstn=0, asynchronous):
  - state=1, ref_seed=1, step_cnt=0.
  - valid_out, bit_out, wrap_out, seed_err_out, period_valid_out = 0; period_out = 0.
- Load (load_in=1):
  - If seed_in≠0: state and ref_seed ← seed_in.
  - If seed_in=0: state and ref_seed ← 1, and seed_err_out ← 1.
  - Always: step_cnt ← 0, period_out ← 0, period_valid_out ← 0, valid_out ← 0, wrap_out ← 0.
  - shift_in is ignored in the same cycle.
- Shift (shift_in=1, load_in=0):
  - state ← next, bit_out ← state[0], valid_out ← 1.
  - If next==ref_seed: wrap_out ← 1, period_out ← step_cnt+1, period_valid_out ← 1, step_cnt ← 0.
  - Otherwise: step_cnt ← step_cnt+1, wrap_out ← 0.
- Idle (neither load_in nor shift_in):
  - state, bit_out, period_out, period_valid_out hold.
  - valid_out, wrap_out, seed_err_out ← 0.
- Because TAP_MASK[0]=1 the map is a bijection, so:
  - A nonzero state never reaches 0.
  - The state always returns to ref_seed within 2^BIT_WIDTH−1 steps, so step_cnt+1 cannot overflow BIT_WIDTH bits.
- A non-primitive TAP_MASK yields a shorter period; this is legal and period_out reports it.
- period_valid_out stays set across later wraps; each wrap overwrites period_out with the same value.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Latency is 1 cycle: a load or shift sampled at edge N is visible on res_out, valid_out, bit_out, wrap_out and seed_err_out after edge N.
- Back-to-back shifts are allowed every cycle, giving a throughput of 1 step/cycle.
- Simultaneous load_in and shift_in: load wins and no step occurs.
- Reset asserted mid-sequence: all outputs go to their reset values immediately, without waiting for a clock edge.
- Reset deassertion is synchronised externally; the first edge after release behaves as normal operation.
- BIT_WIDTH=2 with TAP_MASK=2'b11 gives period 3; this is a supported corner case.

## Test plan
- Reset: BIT_WIDTH=4, TAP_MASK=4'h3, pulse rstn low with no clock.
  - Required: res_out=4'h1 immediately; every other output is 0.
- Full cycle: load seed 4'h8, then 15 consecutive shifts.
  - res_out must follow 4,2,9,C,6,B,5,A,D,E,F,7,3,1,8.
  - wrap_out is high only after the 15th shift, then period_out=15 and period_valid_out=1.
  - valid_out is high in all 15 cycles.
- Zero seed: load seed 4'h0.
  - Required: res_out=4'h1 and seed_err_out high for exactly 1 cycle.
  - A following full cycle of 15 shifts reports period_out=15.
- Priority: load_in=1 and shift_in=1 together with seed 4'h6.
  - Required: res_out=4'h6, valid_out=0, step_cnt restarts; the next shift gives res_out=4'hB.
- Gapped shifts: seed 4'h8, shifts on alternate cycles.
  - res_out holds between shifts and valid_out pulses only after each shift.
  - bit_out sequence is 0,0,0,1 for the first four shifts.
  - Wrap still occurs on the 15th shift with period_out=15.
- Default parameters (8, 8'h1D): load seed 8'h01 and run 255 shifts.
  - Required: wrap after shift 255 with period_out=255.
  - Assert rstn at shift 100 of a second run: res_out=8'h01, period_valid_out=0.

Source files
------------

// File: rtl/lfsr_gen_if.sv
// Bus between an LFSR consumer and lfsr_gen: seed/step controls in,
// pattern, serial bit and measured-period status out.
interface lfsr_gen_if #(
   parameter int BIT_WIDTH = 8
);
   logic                 load_in;
   logic [BIT_WIDTH-1:0] seed_in;
   logic                 shift_in;
   logic                 valid_out;
   logic [BIT_WIDTH-1:0] res_out;
   logic                 bit_out;
   logic                 wrap_out;
   logic [BIT_WIDTH-1:0] period_out;
   logic                 period_valid_out;
   logic                 seed_err_out;

   modport master (
      output load_in, seed_in, shift_in,
      input  valid_out, res_out, bit_out, wrap_out,
             period_out, period_valid_out, seed_err_out
   );

   modport slave (
      input  load_in, seed_in, shift_in,
      output valid_out, res_out, bit_out, wrap_out,
             period_out, period_valid_out, seed_err_out
   );
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with programmable taps, zero-seed protection,
// serial bit output and on-the-fly period measurement against the loaded seed.
module lfsr_gen #(
   parameter int                   BIT_WIDTH = 8,
   parameter logic [BIT_WIDTH-1:0] TAP_MASK  = BIT_WIDTH'(8'h1D)
) (
   input logic       clk,
   input logic       rstn,
   lfsr_gen_if.slave bus
);

   if (BIT_WIDTH < 2 || BIT_WIDTH > 32) begin : g_width_check
      $error("lfsr_gen: BIT_WIDTH=%0d outside legal range 2..32", BIT_WIDTH);
   end

   // Without tap 0 the map is not a bijection and the seed may never recur.
   if (TAP_MASK[0] != 1'b1) begin : g_tap_check
      $error("lfsr_gen: TAP_MASK[0] must be 1");
   end

   logic [BIT_WIDTH-1:0] state_q,        state_d;
   logic [BIT_WIDTH-1:0] ref_seed_q,     ref_seed_d;
   logic [BIT_WIDTH-1:0] step_cnt_q,     step_cnt_d;
   logic [BIT_WIDTH-1:0] period_q,       period_d;
   logic                 valid_q,        valid_d;
   logic                 bit_q,          bit_d;
   logic                 wrap_q,         wrap_d;
   logic                 period_valid_q, period_valid_d;
   logic                 seed_err_q,     seed_err_d;

   logic                 fb;
   logic [BIT_WIDTH-1:0] next_state;

   assign fb         = ^(state_q & TAP_MASK);
   assign next_state = {fb, state_q[BIT_WIDTH-1:1]};

   always_comb begin
      state_d        = state_q;
      ref_seed_d     = ref_seed_q;
      step_cnt_d     = step_cnt_q;
      period_d       = period_q;
      period_valid_d = period_valid_q;
      bit_d          = bit_q;
      valid_d        = 1'b0;
      wrap_d         = 1'b0;
      seed_err_d     = 1'b0;

      if (bus.load_in) begin
         // A zero seed would lock the register at zero forever.
         if (bus.seed_in == '0) begin
            state_d    = BIT_WIDTH'(1);
            ref_seed_d = BIT_WIDTH'(1);
            seed_err_d = 1'b1;
         end else begin
            state_d    = bus.seed_in;
            ref_seed_d = bus.seed_in;
         end
         step_cnt_d     = '0;
         period_d       = '0;
         period_valid_d = 1'b0;
      end else if (bus.shift_in) begin
         state_d = next_state;
         bit_d   = state_q[0];
         valid_d = 1'b1;
         if (next_state == ref_seed_q) begin
            wrap_d         = 1'b1;
            period_d       = step_cnt_q + BIT_WIDTH'(1);
            period_valid_d = 1'b1;
            step_cnt_d     = '0;
         end else begin
            step_cnt_d = step_cnt_q + BIT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q        <= BIT_WIDTH'(1);
         ref_seed_q     <= BIT_WIDTH'(1);
         step_cnt_q     <= '0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         valid_q        <= 1'b0;
         bit_q          <= 1'b0;
         wrap_q         <= 1'b0;
         seed_err_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         ref_seed_q     <= ref_seed_d;
         step_cnt_q     <= step_cnt_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
         valid_q        <= valid_d;
         bit_q          <= bit_d;
         wrap_q         <= wrap_d;
         seed_err_q     <= seed_err_d;
      end
   end

   assign bus.res_out          = state_q;
   assign bus.valid_out        = valid_q;
   assign bus.bit_out          = bit_q;
   assign bus.wrap_out         = wrap_q;
   assign bus.period_out       = period_q;
   assign bus.period_valid_out = period_valid_q;
   assign bus.seed_err_out     = seed_err_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: a 4-bit x^4+x+1 instance driven from a vector
// table plus gapped/reset sequences, and the default 8-bit instance over a full period.
module tb_lfsr_gen;

   logic clk = 1'b0;
   logic rstn4;
   logic rstn8;

   always #5 clk = ~clk;

   lfsr_gen_if #(.BIT_WIDTH(4)) bus4 ();
   lfsr_gen_if #(.BIT_WIDTH(8)) bus8 ();

   lfsr_gen #(.BIT_WIDTH(4), .TAP_MASK(4'h3)) dut4 (
      .clk  (clk),
      .rstn (rstn4),
      .bus  (bus4)
   );

   lfsr_gen dut8 (
      .clk  (clk),
      .rstn (rstn8),
      .bus  (bus8)
   );

   typedef struct {
      logic       load;
      logic       shift;
      logic [3:0] seed;
      logic [3:0] res;
      logic       valid;
      logic       bitv;
      logic       wrap;
      logic       err;
      logic [3:0] period;
      logic       pv;
   } vec_t;

   vec_t       vecs[$];
   logic [3:0] seq4 [15];
   int         checks   = 0;
   int         failures = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   function automatic void addVec(input logic ld, input logic sh, input logic [3:0] sd,
                                  input logic [3:0] rs, input logic vl, input logic bt,
                                  input logic wr, input logic er, input logic [3:0] pd,
                                  input logic pv);
      vec_t v;
      v.load = ld; v.shift = sh; v.seed = sd; v.res = rs; v.valid = vl;
      v.bitv = bt; v.wrap = wr; v.err = er; v.period = pd; v.pv = pv;
      vecs.push_back(v);
   endfunction

   task automatic applyStimulus(input logic ld, input logic sh, input logic [3:0] sd);
      bus4.load_in  = ld;
      bus4.shift_in = sh;
      bus4.seed_in  = sd;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus8(input logic ld, input logic sh, input logic [7:0] sd);
      bus8.load_in  = ld;
      bus8.shift_in = sh;
      bus8.seed_in  = sd;
      @(posedge clk);
      #1;
   endtask

   task automatic checkVec(input vec_t v, input int idx);
      checkOutput($sformatf("v%0d.res", idx),    32'(bus4.res_out),          32'(v.res));
      checkOutput($sformatf("v%0d.valid", idx),  32'(bus4.valid_out),        32'(v.valid));
      checkOutput($sformatf("v%0d.bit", idx),    32'(bus4.bit_out),          32'(v.bitv));
      checkOutput($sformatf("v%0d.wrap", idx),   32'(bus4.wrap_out),         32'(v.wrap));
      checkOutput($sformatf("v%0d.err", idx),    32'(bus4.seed_err_out),     32'(v.err));
      checkOutput($sformatf("v%0d.period", idx), 32'(bus4.period_out),       32'(v.period));
      checkOutput($sformatf("v%0d.pv", idx),     32'(bus4.period_valid_out), 32'(v.pv));
   endtask

   task automatic checkReset4(input string tag);
      checkOutput({tag, ".res"},    32'(bus4.res_out),          32'h1);
      checkOutput({tag, ".valid"},  32'(bus4.valid_out),        32'h0);
      checkOutput({tag, ".bit"},    32'(bus4.bit_out),          32'h0);
      checkOutput({tag, ".wrap"},   32'(bus4.wrap_out),         32'h0);
      checkOutput({tag, ".err"},    32'(bus4.seed_err_out),     32'h0);
      checkOutput({tag, ".period"}, 32'(bus4.period_out),       32'h0);
      checkOutput({tag, ".pv"},     32'(bus4.period_valid_out), 32'h0);
   endtask

   function automatic logic [7:0] next8(input logic [7:0] s);
      return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
   endfunction

   initial begin
      logic [3:0] prev;
      logic [3:0] gapBits [4];
      logic [7:0] model8;
      int         earlyWrap;

      seq4    = '{4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB, 4'h5, 4'hA,
                  4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h8};
      gapBits = '{1'b0, 1'b0, 1'b0, 1'b1};

      // Load 8 and walk the full 15-state cycle, then idle.
      addVec(1'b1, 1'b0, 4'h8, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      prev = 4'h8;
      for (int k = 0; k < 15; k++) begin
         addVec(1'b0, 1'b1, 4'h0, seq4[k], 1'b1, prev[0], k == 14, 1'b0,
                (k == 14) ? 4'd15 : 4'd0, k == 14);
         prev = seq4[k];
      end
      addVec(1'b0, 1'b0, 4'h0, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 1'b1);

      // Zero seed is replaced by 1 and flagged for one cycle.
      addVec(1'b1, 1'b0, 4'h0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0);
      addVec(1'b0, 1'b0, 4'h0, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      prev = 4'h1;
      for (int k = 0; k < 15; k++) begin
         addVec(1'b0, 1'b1, 4'h0, seq4[(14 + k) % 15], 1'b1, prev[0], k == 14, 1'b0,
                (k == 14) ? 4'd15 : 4'd0, k == 14);
         prev = seq4[(14 + k) % 15];
      end

      // A few steps so the step counter is nonzero before the priority load.
      addVec(1'b0, 1'b1, 4'h0, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 1'b1);
      addVec(1'b0, 1'b1, 4'h0, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 1'b1);
      addVec(1'b0, 1'b1, 4'h0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 1'b1);

      // Load and shift together: load wins, then a full cycle from 6.
      addVec(1'b1, 1'b1, 4'h6, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      prev = 4'h6;
      for (int k = 0; k < 15; k++) begin
         addVec(1'b0, 1'b1, 4'h0, seq4[(5 + k) % 15], 1'b1, prev[0], k == 14, 1'b0,
                (k == 14) ? 4'd15 : 4'd0, k == 14);
         prev = seq4[(5 + k) % 15];
      end

      bus4.load_in = 1'b0; bus4.shift_in = 1'b0; bus4.seed_in = 4'h0;
      bus8.load_in = 1'b0; bus8.shift_in = 1'b0; bus8.seed_in = 8'h0;
      rstn4 = 1'b1;
      rstn8 = 1'b1;
      #2;
      rstn4 = 1'b0;
      rstn8 = 1'b0;
      #1;
      checkReset4("reset4");
      checkOutput("reset8.res", 32'(bus8.res_out), 32'h01);
      @(negedge clk);
      @(negedge clk);
      rstn4 = 1'b1;
      rstn8 = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].load, vecs[i].shift, vecs[i].seed);
         checkVec(vecs[i], i);
      end

      // Gapped shifts: state holds and valid drops on every idle cycle.
      applyStimulus(1'b1, 1'b0, 4'h8);
      checkOutput("gap.load", 32'(bus4.res_out), 32'h8);
      for (int k = 0; k < 15; k++) begin
         applyStimulus(1'b0, 1'b1, 4'h0);
         checkOutput($sformatf("gap%0d.res", k),   32'(bus4.res_out),   32'(seq4[k]));
         checkOutput($sformatf("gap%0d.valid", k), 32'(bus4.valid_out), 32'h1);
         checkOutput($sformatf("gap%0d.wrap", k),  32'(bus4.wrap_out),  32'(k == 14));
         if (k < 4)
            checkOutput($sformatf("gap%0d.bit", k), 32'(bus4.bit_out), 32'(gapBits[k]));
         applyStimulus(1'b0, 1'b0, 4'h0);
         checkOutput($sformatf("gap%0d.hold", k),  32'(bus4.res_out),   32'(seq4[k]));
         checkOutput($sformatf("gap%0d.idle", k),  32'(bus4.valid_out), 32'h0);
      end
      checkOutput("gap.period", 32'(bus4.period_out),       32'd15);
      checkOutput("gap.pv",     32'(bus4.period_valid_out), 32'h1);

      // Asynchronous reset between edges, right after a shift.
      applyStimulus(1'b1, 1'b0, 4'h5);
      applyStimulus(1'b0, 1'b1, 4'h0);
      bus4.shift_in = 1'b0;
      #2;
      rstn4 = 1'b0;
      #1;
      checkReset4("areset4");
      @(negedge clk);
      rstn4 = 1'b1;

      // Default 8-bit instance: full maximal period from seed 01.
      applyStimulus8(1'b1, 1'b0, 8'h01);
      checkOutput("w8.load", 32'(bus8.res_out), 32'h01);
      model8    = 8'h01;
      earlyWrap = 0;
      for (int n = 1; n <= 255; n++) begin
         applyStimulus8(1'b0, 1'b1, 8'h00);
         model8 = next8(model8);
         checkOutput($sformatf("w8s%0d.res", n), 32'(bus8.res_out), 32'(model8));
         if (n < 255 && bus8.wrap_out) earlyWrap++;
      end
      checkOutput("w8.early_wrap", 32'(earlyWrap),             32'd0);
      checkOutput("w8.res_end",    32'(bus8.res_out),          32'h01);
      checkOutput("w8.wrap",       32'(bus8.wrap_out),         32'h1);
      checkOutput("w8.period",     32'(bus8.period_out),       32'd255);
      checkOutput("w8.pv",         32'(bus8.period_valid_out), 32'h1);

      // Second run interrupted by reset at shift 100.
      applyStimulus8(1'b1, 1'b0, 8'h01);
      checkOutput("w8r.pv_cleared", 32'(bus8.period_valid_out), 32'h0);
      model8 = 8'h01;
      for (int n = 1; n <= 100; n++) begin
         applyStimulus8(1'b0, 1'b1, 8'h00);
         model8 = next8(model8);
      end
      checkOutput("w8r.res100", 32'(bus8.res_out), 32'(model8));
      bus8.shift_in = 1'b0;
      #2;
      rstn8 = 1'b0;
      #1;
      checkOutput("w8r.res",    32'(bus8.res_out),          32'h01);
      checkOutput("w8r.pv",     32'(bus8.period_valid_out), 32'h0);
      checkOutput("w8r.period", 32'(bus8.period_out),       32'h0);
      checkOutput("w8r.valid",  32'(bus8.valid_out),        32'h0);
      @(negedge clk);
      rstn8 = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
